// File: rtl/bcd_disp_pkg.sv
// Purpose: shared constants and types for the BCD seven-segment scan display.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package bcd_disp_pkg;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // All anodes released (active-low)
  localparam logic [3:0] AN_OFF = 4'b1111;

  // SCAN drives one digit; GUARD is the single dark cycle between digits
  typedef enum logic {
    SCAN  = 1'b0,
    GUARD = 1'b1
  } scan_state_t;

endpackage

// File: rtl/bcd_to_7seg.sv
// Purpose: nibble to active-low seven-segment pattern, non-BCD nibbles show "E".
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs continuously.
module bcd_to_7seg
  import bcd_disp_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  // Blank wins; otherwise table lookup with A..F folded onto the error glyph
  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (digit)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_E;
      endcase
    end
  end

endmodule

// File: rtl/bcd_display_scan.sv
// Purpose: capture a 4-digit BCD result and time-multiplex it onto a common-anode display.
// Latency: load at edge k captures at edge k; seg/dp/an/bcd_err reflect it at edge k+1.
// Backpressure: none; load is accepted every cycle and never disturbs the scan.
module bcd_display_scan
  import bcd_disp_pkg::*;
#(
  parameter int unsigned REFRESH_DIV   = 100000,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] bcd_in,
  input  logic [3:0]  carry_in,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        bcd_err
);

  localparam int          CW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

  logic [15:0]   cap_q;
  logic [3:0]    carry_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  scan_state_t   state_q, state_d;

  logic [3:0] nib [4];
  logic [3:0] blank_vec;
  logic       zero_above;
  logic       err_any;
  logic [3:0] cur_nib;
  logic       cur_blank;
  logic [6:0] dec_seg;

  // Capture register; reset wins over a coincident load
  always_ff @(posedge clk) begin
    if (reset) begin
      cap_q   <= 16'h0000;
      carry_q <= 4'b0000;
    end else if (load) begin
      cap_q   <= bcd_in;
      carry_q <= carry_in;
    end
  end

  // Scan state, refresh counter and digit index registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SCAN;
      cnt_q   <= '0;
      idx_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state: count through SCAN, spend the final count in GUARD, then step digit
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    case (state_q)
      SCAN: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_d == LAST) state_d = GUARD;
      end
      GUARD: begin
        cnt_d   = '0;
        idx_d   = idx_q + 2'd1;
        state_d = SCAN;
      end
      default: begin
        cnt_d   = '0;
        idx_d   = 2'd0;
        state_d = SCAN;
      end
    endcase
  end

  // Per-digit blanking: a digit blanks when it and everything above are zero;
  // error nibbles are non-zero so they block blanking below them naturally
  always_comb begin
    zero_above = 1'b1;
    blank_vec  = 4'b0000;
    err_any    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      nib[i] = cap_q[4*i +: 4];
    end
    for (int i = 3; i >= 0; i--) begin
      zero_above   = zero_above && (nib[i] == 4'd0);
      blank_vec[i] = BLANK_LEADING && (i != 0) && zero_above;
      err_any      = err_any || (nib[i] > 4'd9);
    end
  end

  // Select the digit under the current anode
  always_comb begin
    cur_nib   = nib[idx_q];
    cur_blank = blank_vec[idx_q];
  end

  bcd_to_7seg u_dec (
    .digit (cur_nib),
    .blank (cur_blank),
    .seg   (dec_seg)
  );

  // Registered outputs; GUARD darkens everything to avoid ghosting between digits
  always_ff @(posedge clk) begin
    if (reset) begin
      seg     <= SEG_BLANK;
      dp      <= 1'b1;
      an      <= AN_OFF;
      bcd_err <= 1'b0;
    end else begin
      bcd_err <= err_any;
      if (state_q == GUARD) begin
        seg <= SEG_BLANK;
        dp  <= 1'b1;
        an  <= AN_OFF;
      end else begin
        seg <= dec_seg;
        dp  <= ~((idx_q == 2'd3) && carry_q[3]);
        an  <= ~(4'b0001 << idx_q);
      end
    end
  end

endmodule

// File: tb/tb_bcd_display_scan.sv
// Purpose: scoreboard bench for bcd_display_scan, both blanking modes side by side.
// Latency: expected output for each edge is queued at that edge and checked half a cycle later.
// Backpressure: none; the monitor consumes one expectation per clock.
module tb_bcd_display_scan;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [15:0] bcd_in;
  logic [3:0]  carry_in;

  logic [6:0] seg1, seg0;
  logic       dp1, dp0;
  logic [3:0] an1, an0;
  logic       err1, err0;

  bcd_display_scan #(.REFRESH_DIV(DIV), .BLANK_LEADING(1'b1)) u_bl1 (
    .clk(clk), .reset(reset), .load(load), .bcd_in(bcd_in), .carry_in(carry_in),
    .seg(seg1), .dp(dp1), .an(an1), .bcd_err(err1)
  );

  bcd_display_scan #(.REFRESH_DIV(DIV), .BLANK_LEADING(1'b0)) u_bl0 (
    .clk(clk), .reset(reset), .load(load), .bcd_in(bcd_in), .carry_in(carry_in),
    .seg(seg0), .dp(dp0), .an(an0), .bcd_err(err0)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       err;
  } exp_t;

  exp_t q1[$];
  exp_t q0[$];

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: edges since reset release, captured value, overflow flag
  int          tick = 0;
  logic [15:0] m_val = 16'h0000;
  logic        m_ovf = 1'b0;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'd0: g = 7'h40;  4'd1: g = 7'h79;  4'd2: g = 7'h24;  4'd3: g = 7'h30;
      4'd4: g = 7'h19;  4'd5: g = 7'h12;  4'd6: g = 7'h02;  4'd7: g = 7'h78;
      4'd8: g = 7'h00;  4'd9: g = 7'h10;
      default: g = 7'h06;
    endcase
    return g;
  endfunction

  // What the display shows after the edge that ends model cycle t
  function automatic exp_t predict(input bit bl, input int t, input logic [15:0] v, input logic ovf);
    exp_t e;
    int phase, d, hi;
    logic [3:0] n;
    phase = t % DIV;
    d     = (t / DIV) % 4;
    hi    = -1;
    e.err = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n = v[4*i +: 4];
      if (n != 4'd0) hi = i;
      if (n > 4'd9) e.err = 1'b1;
    end
    if (phase == DIV - 1) begin
      e.seg = 7'h7F;
      e.dp  = 1'b1;
      e.an  = 4'b1111;
    end else begin
      n     = v[4*d +: 4];
      e.an  = 4'b1111;
      e.an[d] = 1'b0;
      e.dp  = !(d == 3 && ovf);
      e.seg = (bl && d >= 1 && d > hi) ? 7'h7F : glyph(n);
    end
    return e;
  endfunction

  // Model: at every edge queue the expected registered outputs, then apply inputs
  always @(posedge clk) begin
    if (reset) begin
      q1.push_back({7'h7F, 1'b1, 4'b1111, 1'b0});
      q0.push_back({7'h7F, 1'b1, 4'b1111, 1'b0});
      tick  = 0;
      m_val = 16'h0000;
      m_ovf = 1'b0;
    end else begin
      q1.push_back(predict(1'b1, tick, m_val, m_ovf));
      q0.push_back(predict(1'b0, tick, m_val, m_ovf));
      tick = tick + 1;
      if (load) begin
        m_val = bcd_in;
        m_ovf = carry_in[3];
      end
    end
  end

  // Monitor: compare both DUTs against the queued expectation away from the edge
  always @(negedge clk) begin
    exp_t e1, e0;
    if (q1.size() > 0 && q0.size() > 0) begin
      e1 = q1.pop_front();
      e0 = q0.pop_front();
      vectors++;
      if ({seg1, dp1, an1, err1} !== e1) begin
        miscompares++;
        $display("FAIL blank_on @%0t: got seg=%h dp=%b an=%b err=%b, want seg=%h dp=%b an=%b err=%b",
                 $time, seg1, dp1, an1, err1, e1.seg, e1.dp, e1.an, e1.err);
      end
      vectors++;
      if ({seg0, dp0, an0, err0} !== e0) begin
        miscompares++;
        $display("FAIL blank_off @%0t: got seg=%h dp=%b an=%b err=%b, want seg=%h dp=%b an=%b err=%b",
                 $time, seg0, dp0, an0, err0, e0.seg, e0.dp, e0.an, e0.err);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] c);
    load     = 1'b1;
    bcd_in   = v;
    carry_in = c;
    cyc(1);
    load     = 1'b0;
  endtask

  function automatic logic [15:0] rand_bcd();
    logic [15:0] v;
    int keep;
    v = 16'h0000;
    keep = $urandom_range(0, 4);
    for (int i = 0; i < 4; i++) begin
      if (i < keep) v[4*i +: 4] = 4'($urandom_range(0, 9));
    end
    return v;
  endfunction

  initial begin
    int guard_cnt;
    reset = 1'b1; load = 1'b0; bcd_in = 16'h0000; carry_in = 4'b0000;
    cyc(2);
    reset = 1'b0;
    cyc(20);

    do_load(16'h1234, 4'b0000);  cyc(20);
    do_load(16'h0005, 4'b0000);  cyc(20);
    do_load(16'h00A0, 4'b0000);  cyc(20);
    do_load(16'h9999, 4'b1000);  cyc(20);
    do_load(16'hF000, 4'b0111);  cyc(18);

    // Reset coinciding with a load while digit 2 is on the display
    guard_cnt = 0;
    while ((((tick / DIV) % 4) != 2 || (tick % DIV) != 1) && guard_cnt < 64) begin
      cyc(1);
      guard_cnt++;
    end
    if (guard_cnt >= 64) begin
      miscompares++;
      $display("FAIL digit2_align: no digit-2 slot within 64 cycles, want one within 16");
    end
    reset = 1'b1; load = 1'b1; bcd_in = 16'h4321; carry_in = 4'b1000;
    cyc(1);
    reset = 1'b0; load = 1'b0;
    cyc(12);

    // Load held high re-captures each cycle without disturbing the scan
    load = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bcd_in   = 16'($urandom);
      carry_in = 4'($urandom);
      cyc(1);
    end
    load = 1'b0;
    cyc(8);

    // Randomised traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      load  = ($urandom_range(0, 7) == 0);
      bcd_in   = $urandom_range(0, 1) ? rand_bcd() : 16'($urandom);
      carry_in = 4'($urandom);
      cyc(1);
    end
    reset = 1'b0; load = 1'b0;
    cyc(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
